// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector with saturating hit count.
// Define SEQDET_MASK_EN to add the mask_in port and per-bit don't-care matching.
module seq_detector_param #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [PAT_W-1:0] pat_in,
`ifdef SEQDET_MASK_EN
   input  logic [PAT_W-1:0] mask_in,
`endif
   input  logic             overlap,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             cnt_clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             armed
);
   localparam int FW = $clog2(PAT_W + 1);
   typedef enum logic [1:0] {IDLE, FILL, DETECT} state_t;
   state_t           state_q, state_d;
   logic [PAT_W-1:0] pattern_q, pattern_d, hist_q, hist_d, hist_n, care;
   logic [FW-1:0]    fill_q, fill_d, fill_n;
   logic             match_q, match_d, accept, hit;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SEQDET_MASK_EN
   logic [PAT_W-1:0] mask_q, mask_d;
   assign care = mask_q;
`else
   assign care = '1;
`endif
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
`ifdef SEQDET_MASK_EN
      mask_d    = mask_q;
`endif
      accept = in_valid && state_q != IDLE && !load;
      hist_n = {hist_q[PAT_W-2:0], in_bit};
      fill_n = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
      hit    = accept && fill_n == FW'(PAT_W) && ((hist_n ^ pattern_q) & care) == '0;
      if (load) begin
         pattern_d = pat_in;
`ifdef SEQDET_MASK_EN
         mask_d    = mask_in;
`endif
         hist_d    = '0;
         fill_d    = '0;
         state_d   = FILL;
      end else if (accept) begin
         // A non-overlapping hit restarts the window from empty
         hist_d  = (hit && !overlap) ? '0 : hist_n;
         fill_d  = (hit && !overlap) ? '0 : fill_n;
         state_d = (hit && !overlap) ? FILL : (fill_n == FW'(PAT_W)) ? DETECT : FILL;
      end
      match_d = hit;
      cnt_d   = cnt_clr ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         hist_q    <= '0;
         fill_q    <= '0;
         match_q   <= 1'b0;
         cnt_q     <= '0;
`ifdef SEQDET_MASK_EN
         mask_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         cnt_q     <= cnt_d;
`ifdef SEQDET_MASK_EN
         mask_q    <= mask_d;
`endif
      end
   end
   assign match     = match_q;
   assign match_cnt = cnt_q;
   assign armed     = state_q != IDLE;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of seq_detector_param (PAT_W=4/CNT_W=8 and PAT_W=2/CNT_W=2).
module tb_seq_detector_param;
   logic       clk = 1'b0;
   logic       rst = 1'b1, load = 1'b0, overlap = 1'b0, in_valid = 1'b0, in_bit = 1'b0, cnt_clr = 1'b0;
   logic [3:0] pat_a = '0;
   logic [1:0] pat_b = '0;
   logic       m_a, m_b, arm_a, arm_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   int         checks = 0, errors = 0;
`ifdef SEQDET_MASK_EN
   logic [3:0] mask_a = '0;
   logic [1:0] mask_b = '1;
`endif
   always #5 clk = ~clk;
   seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .load(load), .pat_in(pat_a),
`ifdef SEQDET_MASK_EN
      .mask_in(mask_a),
`endif
      .overlap(overlap), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
      .match(m_a), .match_cnt(cnt_a), .armed(arm_a));
   seq_detector_param #(.PAT_W(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .load(load), .pat_in(pat_b),
`ifdef SEQDET_MASK_EN
      .mask_in(mask_b),
`endif
      .overlap(overlap), .in_valid(in_valid), .in_bit(in_bit), .cnt_clr(cnt_clr),
      .match(m_b), .match_cnt(cnt_b), .armed(arm_b));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // Feed n bits MSB-first, checking the selected DUT's match after each accepting edge
   task automatic feed(input string tag, input bit sel, input logic [15:0] bits, input int n, input logic [15:0] exp_m);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_bit = bits[n-1-i];
         tick();
         check($sformatf("%s[%0d]", tag, i), 32'(sel ? m_b : m_a), 32'(exp_m[n-1-i]));
      end
      in_valid = 1'b0;
   endtask
   task automatic do_load(input logic [3:0] pa, input logic [1:0] pb);
      load = 1'b1;
      pat_a = pa;
      pat_b = pb;
      tick();
      load = 1'b0;
   endtask
   initial begin
      tick();
      tick();
      check("rst_match", 32'(m_a), 0);
      check("rst_cnt", 32'(cnt_a), 0);
      check("rst_armed", 32'(arm_a), 0);
      rst = 1'b0;
      tick();
      check("idle_armed", 32'(arm_a), 0);
      do_load(4'b1011, 2'b00);
      check("load_armed", 32'(arm_a), 1);
      overlap = 1'b1;
      feed("ovl", 0, 16'b1011011011, 10, 16'b0001001001);
      check("ovl_cnt", 32'(cnt_a), 3);
      tick();
      check("idle_match", 32'(m_a), 0);
      check("idle_cnt", 32'(cnt_a), 3);
      cnt_clr = 1'b1;
      do_load(4'b1011, 2'b00);
      cnt_clr = 1'b0;
      check("clr_cnt", 32'(cnt_a), 0);
      overlap = 1'b0;
      feed("novl", 0, 16'b1011011011, 10, 16'b0001000001);
      check("novl_cnt", 32'(cnt_a), 2);
      cnt_clr = 1'b1;
      do_load(4'b1111, 2'b11);
      cnt_clr = 1'b0;
      overlap = 1'b1;
      feed("sat", 1, 16'b111111, 6, 16'b011111);
      check("sat_cnt", 32'(cnt_b), 3);
      cnt_clr = 1'b1;
      in_valid = 1'b1;
      in_bit = 1'b1;
      tick();
      cnt_clr = 1'b0;
      in_valid = 1'b0;
      check("clr_hit_match", 32'(m_b), 1);
      check("clr_hit_cnt", 32'(cnt_b), 0);
      do_load(4'b1011, 2'b00);
      feed("pre_ld", 0, 16'b101, 3, 16'b000);
      in_valid = 1'b1;
      in_bit = 1'b1;
      do_load(4'b0110, 2'b00);
      in_valid = 1'b0;
      check("ld_drop", 32'(m_a), 0);
      feed("post_ld", 0, 16'b0110, 4, 16'b0001);
      do_load(4'b1011, 2'b00);
      feed("pre_rst", 0, 16'b101, 3, 16'b000);
      rst = 1'b1;
      load = 1'b1;
      in_valid = 1'b1;
      tick();
      rst = 1'b0;
      load = 1'b0;
      in_valid = 1'b0;
      check("mid_rst_match", 32'(m_a), 0);
      check("mid_rst_cnt", 32'(cnt_a), 0);
      check("mid_rst_armed", 32'(arm_a), 0);
      feed("no_load", 0, 16'b1011, 4, 16'b0000);
      check("no_load_armed", 32'(arm_a), 0);
`ifdef SEQDET_MASK_EN
      mask_a = 4'b1001;
      overlap = 1'b0;
      cnt_clr = 1'b1;
      do_load(4'b1001, 2'b00);
      cnt_clr = 1'b0;
      feed("mask", 0, 16'b1001111110111101, 16, 16'b0001000100010001);
      check("mask_cnt", 32'(cnt_a), 4);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: a runtime-loadable successor to the fixed-pattern sequence-detector FSMs in the sequence-detection suite. It compares a qualified 1-bit input stream against a PAT_W-bit pattern, pulses `match` on each hit, and keeps a saturating hit count. Overlapping and non-overlapping detection are selected at runtime. It sits between a serial bit source and the scoring/monitor logic.

## Interface
- PAT_W, 4, pattern length in bits; must be ≥2.
- CNT_W, 8, match counter width; must be ≥1.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  load `pat_in` and restart detection.
- pat_in  in  PAT_W  pattern. MSB is the first bit received.
- mask_in  in  PAT_W  care mask, 1 = compare. Present only with SEQDET_MASK_EN.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping. Sampled with each valid bit.
- in_valid  in  1  `in_bit` is valid this cycle.
- in_bit  in  1  serial data bit.
- cnt_clr  in  1  clear `match_cnt`.
- match  out  1  one-cycle hit pulse, registered.
- match_cnt  out  CNT_W  saturating hit count.
- armed  out  1  a pattern is loaded (state ≠ IDLE).

## Operation
- Internal registers:
  - `pattern` (PAT_W).
  - `hist` (PAT_W): shift register, newest bit in LSB.
  - `fill`: 0..PAT_W, saturating count of bits accepted since the last restart.
- States:
  - IDLE: no pattern loaded; `in_valid` is ignored.
  - FILL: fill < PAT_W.
  - DETECT: window full.
- Transitions:
  - IDLE → FILL on `load`.
  - FILL → DETECT when an accepted bit makes fill = PAT_W without a hit.
  - On a hit with overlap=0: → FILL, with hist and fill cleared.
  - On a hit with overlap=1: stay in or enter DETECT; hist is kept.
- Accepting a bit (`in_valid`=1, state ≠ IDLE, `load`=0):
  - hist_n = {hist[PAT_W-2:0], in_bit}; fill increments, saturating at PAT_W.
  - Hit when fill_n = PAT_W and hist_n == pattern. With the mask feature, the condition is ((hist_n ^ pattern) & mask) == 0.
- `load` has priority in any non-reset cycle:
  - pattern ← pat_in, and mask ← mask_in when the mask feature is present.
  - hist ← 0, fill ← 0, state → FILL.
  - A concurrent `in_bit` is discarded and `match` is 0 next cycle.
  - `match_cnt` is not affected.
- `match_cnt`:
  - Increments on each hit and saturates at 2^CNT_W−1 (no wrap).
  - `cnt_clr` wins over a concurrent increment; that hit is still pulsed on `match` but not counted.
- Idle cycles (`in_valid`=0) hold all state; `match` is 0.

## Timing
- Reset values: state IDLE; pattern, mask, hist and fill 0; match 0, match_cnt 0, armed 0.
- `rst` overrides `load`, `cnt_clr` and `in_valid` in the same cycle.
- Latency:
  - `match` is high exactly in the cycle after the edge that accepted the completing bit, and for one cycle only.
  - `match_cnt` updates on the same edge as `match` rises.
- `armed` rises the cycle after the first `load` and falls only on reset.
- Back-to-back valid bits: a hit is possible on every cycle with overlap=1 (e.g. pattern all-ones).
- Reset mid-stream: a pending partial match is lost. After reset, IDLE persists until the next `load`.

## Configuration
- SEQDET_MASK_EN defined: `mask_in` port and `mask` register exist; masked bits are don't-care.
- SEQDET_MASK_EN undefined: no `mask_in` port; exact comparison of all PAT_W bits.

## Test plan
- PAT_W=4, load 1011, overlap=1, stream 1011011011 (one bit per cycle) → `match` pulses after bits 4, 7 and 10; match_cnt=3.
- Same stream with overlap=0 → `match` pulses after bits 4 and 10; match_cnt=2.
- CNT_W=2, pattern 11, overlap=1, six consecutive 1s → 5 hits; match_cnt saturates at 3. Pulse cnt_clr in the same cycle as the next hit → match=1 and match_cnt=0.
- Pattern 1011, feed 101, assert `load` with pat_in=0110 in the same cycle as a valid 1 → that bit is dropped and there is no match. Then feed 0110 → one hit after the 4th bit.
- After a partial 101, assert rst → all outputs 0, armed=0. Feed 1011 without `load` → no match.
- With SEQDET_MASK_EN, pattern 1001 and mask 1001 → streams 1001, 1111, 1011 and 1101 each produce one hit (overlap=0).
